// File: rtl/decrypt_seq_pkg.sv
// Shared types and constants for the decrypt sequencing controller.
package decrypt_seq_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_KEY_RST = 3'd1,
        ST_KEY_EXP = 3'd2,
        ST_DECRYPT = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

    // Default phase lengths for the attached decrypt core
    localparam int unsigned DEF_KEY_CYCLES = 32'd9;
    localparam int unsigned DEF_DEC_CYCLES = 32'd12;

    // Width of a counter able to hold the longer of the two phase lengths
    function automatic int unsigned phase_cnt_width(input int unsigned key_cycles,
                                                    input int unsigned dec_cycles);
        int unsigned longest;
        longest = (key_cycles > dec_cycles) ? key_cycles : dec_cycles;
        return $clog2(longest + 32'd1);
    endfunction

endpackage

// File: rtl/seq_phase_counter.sv
// Phase counter: counts cycles spent in a timed state and flags the last one.
// load restarts the count with a new terminal value, clr restarts it with a
// zero terminal value, and the count saturates at the terminal value so it
// can never wrap.
module seq_phase_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] term_i,
    input  logic         en_i,
    output logic         tc_o
);

    localparam logic [W-1:0] CNT_ONE  = W'(1'b1);
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] term_q, term_d;

    // Next count / terminal value selection
    always_comb begin
        cnt_d  = cnt_q;
        term_d = term_q;
        if (clr_i) begin
            cnt_d  = CNT_ZERO;
            term_d = CNT_ZERO;
        end else if (load_i) begin
            cnt_d  = CNT_ZERO;
            term_d = term_i;
        end else if (en_i && (cnt_q != term_q)) begin
            cnt_d  = cnt_q + CNT_ONE;
        end else begin
            cnt_d  = cnt_q;
        end
    end

    // Count and terminal value registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= CNT_ZERO;
            term_q <= CNT_ZERO;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

    assign tc_o = (cnt_q == term_q);

endmodule

// File: rtl/decrypt_seq_ctrl.sv
// Sequencing controller for an external multi-cycle decrypt core.
// Accepts a cyphertext/key request, runs the key schedule only when the
// expanded key is not already cached, runs the decrypt phase, and holds the
// captured plaintext until the consumer takes it.
module decrypt_seq_ctrl
    import decrypt_seq_pkg::*;
#(
    parameter int unsigned KEY_CYCLES = DEF_KEY_CYCLES,
    parameter int unsigned DEC_CYCLES = DEF_DEC_CYCLES
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_cyphertext,
    input  logic [127:0]   in_key,
    input  logic           key_flush,
    input  logic           abort,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_plaintext,
    output logic           core_reset_n_ka,
    output logic           core_en,
    output logic           core_reset_n,
    output logic           core_start,
    output logic [127:0]   core_cyphertext,
    output logic [127:0]   core_initial_key,
    input  logic [127:0]   core_plaintext
);

    localparam int unsigned  CW       = phase_cnt_width(KEY_CYCLES, DEC_CYCLES);
    localparam logic [CW-1:0] KEY_TERM = CW'(KEY_CYCLES - 32'd1);
    localparam logic [CW-1:0] DEC_TERM = CW'(DEC_CYCLES - 32'd1);

    seq_state_e     state_q, state_d;
    logic           cache_valid_q, cache_valid_d;
    logic [127:0]   cached_key_q, cached_key_d;
    logic           flush_pend_q, flush_pend_d;
    logic [127:0]   ct_q, ct_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   pt_q, pt_d;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           ka_q, en_q, crst_q, start_q;

    logic           xfer_s;
    logic           hit_s;
    logic           entry_s;
    logic           load_s;
    logic           clr_s;
    logic           cnt_en_s;
    logic [CW-1:0]  term_s;
    logic           tc_s;

    // The key schedule must keep running once it is in use for this request
    function automatic logic ks_active(input seq_state_e st);
        return (st == ST_KEY_EXP) || (st == ST_DECRYPT) || (st == ST_DONE);
    endfunction

    // The datapath runs from start of decrypt until the result is consumed
    function automatic logic dp_active(input seq_state_e st);
        return (st == ST_DECRYPT) || (st == ST_DONE);
    endfunction

    assign in_ready = in_ready_q & ~abort;
    assign xfer_s   = in_valid & in_ready;
    // A flush arriving with the request wins over the cached key
    assign hit_s    = cache_valid_q & ~key_flush & (in_key == cached_key_q);

    // Next-state, cache and operand/result update logic
    always_comb begin
        state_d       = state_q;
        cache_valid_d = cache_valid_q;
        cached_key_d  = cached_key_q;
        flush_pend_d  = 1'b0;
        ct_d          = ct_q;
        key_d         = key_q;
        pt_d          = pt_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    ct_d  = in_cyphertext;
                    key_d = in_key;
                    if (hit_s) begin
                        state_d = ST_DECRYPT;
                    end else begin
                        // The schedule is about to be reset, so the old key is gone
                        state_d       = ST_KEY_RST;
                        cache_valid_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KEY_RST: begin
                flush_pend_d = flush_pend_q | key_flush;
                if (abort) begin
                    state_d       = ST_IDLE;
                    cache_valid_d = 1'b0;
                end else begin
                    state_d = ST_KEY_EXP;
                end
            end
            ST_KEY_EXP: begin
                flush_pend_d = flush_pend_q | key_flush;
                if (abort) begin
                    state_d       = ST_IDLE;
                    cache_valid_d = 1'b0;
                end else if (tc_s) begin
                    // A flush seen during expansion leaves the result uncached
                    state_d       = ST_DECRYPT;
                    cache_valid_d = ~(flush_pend_q | key_flush);
                    cached_key_d  = key_q;
                end else begin
                    state_d = ST_KEY_EXP;
                end
            end
            ST_DECRYPT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tc_s) begin
                    state_d = ST_DONE;
                    pt_d    = core_plaintext;
                end else begin
                    state_d = ST_DECRYPT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                cache_valid_d = 1'b0;
            end
        endcase
        if (key_flush) begin
            cache_valid_d = 1'b0;
        end else begin
            cache_valid_d = cache_valid_d;
        end
    end

    // Phase counter control: restart on every state change, count in timed states
    always_comb begin
        entry_s  = (state_d != state_q);
        load_s   = entry_s & ((state_d == ST_KEY_EXP) || (state_d == ST_DECRYPT));
        clr_s    = entry_s & ~load_s;
        cnt_en_s = ~entry_s & ((state_q == ST_KEY_EXP) || (state_q == ST_DECRYPT));
        if (state_d == ST_KEY_EXP) begin
            term_s = KEY_TERM;
        end else begin
            term_s = DEC_TERM;
        end
    end

    seq_phase_counter #(
        .W (CW)
    ) u_phase_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (clr_s),
        .load_i  (load_s),
        .term_i  (term_s),
        .en_i    (cnt_en_s),
        .tc_o    (tc_s)
    );

    // State, cache and data registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cache_valid_q <= 1'b0;
            cached_key_q  <= 128'h0;
            flush_pend_q  <= 1'b0;
            ct_q          <= 128'h0;
            key_q         <= 128'h0;
            pt_q          <= 128'h0;
        end else begin
            state_q       <= state_d;
            cache_valid_q <= cache_valid_d;
            cached_key_q  <= cached_key_d;
            flush_pend_q  <= flush_pend_d;
            ct_q          <= ct_d;
            key_q         <= key_d;
            pt_q          <= pt_d;
        end
    end

    // Control outputs registered from the next state so they track state_q exactly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ka_q        <= 1'b0;
            en_q        <= 1'b0;
            crst_q      <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            ka_q        <= cache_valid_d | ks_active(state_d);
            en_q        <= cache_valid_d | ks_active(state_d);
            crst_q      <= dp_active(state_d);
            start_q     <= dp_active(state_d);
        end
    end

    assign out_valid        = out_valid_q;
    assign out_plaintext    = pt_q;
    assign core_reset_n_ka  = ka_q;
    assign core_en          = en_q;
    assign core_reset_n     = crst_q;
    assign core_start       = start_q;
    assign core_cyphertext  = ct_q;
    assign core_initial_key = key_q;

endmodule

// File: tb/tb_decrypt_seq_ctrl.sv
// Directed self-checking bench for decrypt_seq_ctrl with a stand-in core model.
module tb_decrypt_seq_ctrl;

    localparam int BUDGET = 60;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_cyphertext;
    logic [127:0] in_key;
    logic         key_flush;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_plaintext;
    logic         core_reset_n_ka;
    logic         core_en;
    logic         core_reset_n;
    logic         core_start;
    logic [127:0] core_cyphertext;
    logic [127:0] core_initial_key;
    logic [127:0] core_plaintext;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] CT1  = 128'haa26d13908d945f088a6806ab3eac449;
    localparam logic [127:0] CT2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT3  = 128'hdeadbeefcafef00d0badc0de12345678;
    localparam logic [127:0] KEYA = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [127:0] KEYB = 128'hfedcba9876543210f0e1d2c3b4a59687;

    // Stand-in for the decrypt core: any fixed mix of both operands will do
    function automatic logic [127:0] core_model(input logic [127:0] ct, input logic [127:0] key);
        return ct ^ {key[63:0], key[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
    endfunction

    assign core_plaintext = core_model(core_cyphertext, core_initial_key);

    decrypt_seq_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_cyphertext    (in_cyphertext),
        .in_key           (in_key),
        .key_flush        (key_flush),
        .abort            (abort),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_plaintext    (out_plaintext),
        .core_reset_n_ka  (core_reset_n_ka),
        .core_en          (core_en),
        .core_reset_n     (core_reset_n),
        .core_start       (core_start),
        .core_cyphertext  (core_cyphertext),
        .core_initial_key (core_initial_key),
        .core_plaintext   (core_plaintext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transfer one request and count control activity until out_valid (bounded)
    task automatic run_req(input logic [127:0] ct, input logic [127:0] key, input logic flush,
                           output int lat, output int ka_low, output int en_hi, output int st_hi);
        in_cyphertext = ct;
        in_key        = key;
        key_flush     = flush;
        in_valid      = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        key_flush = 1'b0;
        lat = 0; ka_low = 0; en_hi = 0; st_hi = 0;
        while (!out_valid && lat < BUDGET) begin
            if (!core_reset_n_ka) ka_low++;
            if (core_en && !core_start) en_hi++;
            if (core_start) st_hi++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Let the consumer take the result and confirm the return to IDLE
    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq(tag, {126'd0, out_valid, in_ready}, 128'd1);
    endtask

    int lat, ka_low, en_hi, st_hi;
    logic [127:0] held;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_cyphertext = 128'h0; in_key = 128'h0;
        key_flush = 1'b0; abort = 1'b0; out_ready = 1'b0;
        #23;
        check_eq("rst_ctrl", {122'd0, in_ready, out_valid, core_reset_n_ka, core_en, core_reset_n, core_start}, 128'd0);
        check_eq("rst_pt", out_plaintext, 128'h0);
        check_eq("rst_ops", core_cyphertext | core_initial_key, 128'h0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rel_ready", {127'd0, in_ready}, 128'd1);

        // abort blocks acceptance in IDLE
        abort = 1'b1; #1;
        check_eq("idle_abort_ready", {127'd0, in_ready}, 128'd0);
        abort = 1'b0; #1;

        // Miss
        run_req(CT1, KEYA, 1'b0, lat, ka_low, en_hi, st_hi);
        check_eq("miss_lat", lat, 22);
        check_eq("miss_ka_low", ka_low, 1);
        check_eq("miss_en_hi", en_hi, 9);
        check_eq("miss_start_hi", st_hi, 12);
        check_eq("miss_core_ct", core_cyphertext, CT1);
        check_eq("miss_core_key", core_initial_key, KEYA);
        check_eq("miss_pt", out_plaintext, core_model(CT1, KEYA));

        // Back-pressure for 5 cycles
        held = out_plaintext;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("bp_state", {126'd0, out_valid, in_ready}, 128'd2);
            check_eq("bp_pt", out_plaintext, held);
        end
        release_out("miss_release");

        // Hit
        run_req(CT2, KEYA, 1'b0, lat, ka_low, en_hi, st_hi);
        check_eq("hit_lat", lat, 12);
        check_eq("hit_ka_low", ka_low, 0);
        check_eq("hit_start_hi", st_hi, 12);
        check_eq("hit_pt", out_plaintext, core_model(CT2, KEYA));

        // abort in DONE is ignored
        abort = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("done_abort_valid", {127'd0, out_valid}, 128'd1);
        check_eq("done_abort_pt", out_plaintext, core_model(CT2, KEYA));
        abort = 1'b0;
        release_out("hit_release");

        // Flush then same key: full expansion again
        key_flush = 1'b1;
        @(posedge clk); #1;
        key_flush = 1'b0;
        run_req(CT3, KEYA, 1'b0, lat, ka_low, en_hi, st_hi);
        check_eq("flush_lat", lat, 22);
        check_eq("flush_en_hi", en_hi, 9);
        check_eq("flush_pt", out_plaintext, core_model(CT3, KEYA));
        release_out("flush_release");

        // Abort on KEY_EXP cycle 4
        in_cyphertext = CT1; in_key = KEYB; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("abort_in_keyexp", {126'd0, core_en, core_start}, 128'd2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; #1;
        check_eq("abort_idle", {126'd0, out_valid, in_ready}, 128'd1);
        check_eq("abort_ka", {127'd0, core_reset_n_ka}, 128'd0);
        run_req(CT2, KEYB, 1'b0, lat, ka_low, en_hi, st_hi);
        check_eq("post_abort_lat", lat, 22);
        check_eq("post_abort_pt", out_plaintext, core_model(CT2, KEYB));
        release_out("abort_release");

        // Reset on DECRYPT cycle 6 of a hit
        in_cyphertext = CT3; in_key = KEYB; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check_eq("pre_rst_start", {127'd0, core_start}, 128'd1);
        reset_n = 1'b0; #1;
        check_eq("midrst_ctrl", {122'd0, in_ready, out_valid, core_reset_n_ka, core_en, core_reset_n, core_start}, 128'd0);
        check_eq("midrst_data", out_plaintext | core_cyphertext | core_initial_key, 128'h0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_rel", {126'd0, out_valid, in_ready}, 128'd1);
        run_req(CT1, KEYB, 1'b0, lat, ka_low, en_hi, st_hi);
        check_eq("post_rst_lat", lat, 22);
        release_out("rst_release");

        // Flush coinciding with a transfer of the cached key is a miss
        run_req(CT2, KEYB, 1'b1, lat, ka_low, en_hi, st_hi);
        check_eq("flush_xfer_lat", lat, 22);
        check_eq("flush_xfer_pt", out_plaintext, core_model(CT2, KEYB));
        release_out("flush_xfer_release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decrypt_seq_ctrl.md
DECRYPT_SEQ_CTRL -- requirements
Module: decrypt_seq_ctrl

Interface
REQ-001 Parameter KEY_CYCLES, default 9, SHALL be the number of cycles the decrypt core's key schedule is held enabled.
REQ-002 Parameter DEC_CYCLES, default 12, SHALL be the number of cycles from core start until core plaintext is valid.
REQ-003 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL qualify a request: cyphertext plus key.
REQ-006 in_ready  output  1  SHALL indicate a request is accepted this cycle.
REQ-007 in_cyphertext  input  128  SHALL be the block to decrypt.
REQ-008 in_key  input  128  SHALL be the 128-bit initial key.
REQ-009 key_flush  input  1  SHALL invalidate the cached expanded key.
REQ-010 abort  input  1  SHALL cancel an in-flight request.
REQ-011 out_valid / out_ready  output / input  1 / 1  SHALL be the result handshake.
REQ-012 out_plaintext  output  128  SHALL be the registered result.
REQ-013 core_reset_n_ka, core_en, core_reset_n, core_start  outputs  1 each  SHALL drive the decrypt core's key-schedule reset, key-schedule enable, datapath reset and start.
REQ-014 core_cyphertext, core_initial_key  outputs  128 each  SHALL be registered operands to the core.
REQ-015 core_plaintext  input  128  SHALL be the core result.

Function
REQ-016 FSM SHALL have states IDLE, KEY_RST, KEY_EXP, DECRYPT, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE with abort=0; a transfer occurs when in_valid & in_ready.
REQ-018 On transfer, in_cyphertext and in_key SHALL be latched into core_cyphertext and core_initial_key.
REQ-019 On transfer with cache_valid=1 and in_key equal to the cached key: IDLE->DECRYPT (hit). Otherwise: IDLE->KEY_RST (miss).
REQ-020 KEY_RST SHALL last 1 cycle with core_reset_n_ka=0 and core_en=0, then go to KEY_EXP.
REQ-021 KEY_EXP SHALL last exactly KEY_CYCLES cycles with core_reset_n_ka=1 and core_en=1, then set cache_valid=1, record the cached key, and go to DECRYPT.
REQ-022 While cache_valid=1, core_reset_n_ka and core_en SHALL stay 1 in all states.
REQ-023 DECRYPT SHALL last exactly DEC_CYCLES cycles with core_reset_n=1 and core_start=1; on the last cycle, core_plaintext SHALL be captured into out_plaintext and the FSM SHALL go to DONE.
REQ-024 In DONE, out_valid SHALL be 1 and out_plaintext stable until out_ready=1; then core_reset_n=0, core_start=0, and the FSM returns to IDLE.
REQ-025 core_reset_n and core_start SHALL be 0 in every state except DECRYPT and DONE.
REQ-026 Latency from the transfer edge to out_valid SHALL be 1+KEY_CYCLES+DEC_CYCLES cycles on a miss and DEC_CYCLES cycles on a hit.
REQ-027 The phase counter SHALL be $clog2(max(KEY_CYCLES,DEC_CYCLES)+1) bits, SHALL clear on every state entry, and SHALL never wrap.
REQ-028 key_flush SHALL clear cache_valid next cycle in any state.
REQ-029 If key_flush arrives during KEY_EXP, the expansion SHALL complete but SHALL leave cache_valid=0.
REQ-030 If key_flush and a transfer coincide in IDLE, the request SHALL be treated as a miss.
REQ-031 abort in KEY_RST, KEY_EXP or DECRYPT SHALL return the FSM to IDLE next cycle with out_valid=0.
REQ-032 abort in KEY_RST or KEY_EXP SHALL also clear cache_valid.
REQ-033 abort in DONE SHALL be ignored.

Reset
REQ-034 Asserting reset_n low SHALL immediately force state IDLE and clear cache_valid and the counter.
REQ-035 Under reset, out_valid, core_reset_n_ka, core_en, core_reset_n and core_start SHALL be 0, and out_plaintext, core_cyphertext, core_initial_key and the cached key SHALL be 128'h0.
REQ-036 in_ready SHALL be 0 during reset and 1 on the first cycle after release.
REQ-037 Reset mid-operation SHALL discard the request without asserting out_valid.

Structure
REQ-038 Package decrypt_seq_pkg SHALL hold the state enum and the default KEY_CYCLES and DEC_CYCLES constants.
REQ-039 The phase counter (load, clear, terminal-count flag) SHALL be sub-module seq_phase_counter.
REQ-040 The decrypt core SHALL be instantiated outside this block.

Verification
REQ-041 Miss: reset, then transfer cyphertext 128'haa26d13908d945f088a6806ab3eac449 and key 128'h0123456789abcdef0123456789abcdef -> core_reset_n_ka low 1 cycle, core_en high 9 cycles, core_start high 12 cycles, out_valid 22 cycles after the transfer, out_plaintext equal to the core-model output.
REQ-042 Hit: repeat the same key with a new cyphertext -> KEY_RST and KEY_EXP skipped, out_valid 12 cycles after the transfer.
REQ-043 Flush: pulse key_flush, then send the same key -> full key expansion reruns and latency is 22 cycles.
REQ-044 Back-pressure: hold out_ready=0 for 5 cycles -> out_valid and out_plaintext stable, in_ready=0 throughout.
REQ-045 Abort: assert abort on KEY_EXP cycle 4 -> IDLE next cycle, cache_valid=0, no out_valid, and the next same-key request is a miss.
REQ-046 Reset in DECRYPT: drop reset_n on cycle 6 -> all outputs 0 immediately, in_ready=1 on the cycle after release.
